sram_sp_init: RTL and testbench
===============================

Name: sram_sp_init

Overview:
- Parametrised single-port synchronous SRAM. It generalises the fixed 4x1 lookup memory to configurable width, depth and power-up content.
- A hardware init sweep loads the content pattern after reset or on request.
- Adds write capability, a registered read and a req/ready handshake.
- Sits as a local scratch or lookup store behind a simple master; that master must wait for ready before accessing it.

Parameters:
- DATA_W, 8, word width in bits (>=1)
- ADDR_W, 2, address width in bits (>=1)
- DEPTH, 4, number of implemented words (1 .. 2**ADDR_W)
- INIT_MODE, 1, content written by the init sweep: 0 = all zeros; 1 = word i is {DATA_W{i[0]}} (even addresses 0, odd addresses all ones); 2 = word i is i zero-extended/truncated to DATA_W

Ports:
- clk  input  1  single clock; everything is updated on its rising edge
- rst_n  input  1  asynchronous active-low reset
- clr  input  1  request to re-run the init sweep
- req  input  1  access request
- we  input  1  1 = write, 0 = read; qualified by req
- addr  input  ADDR_W  access address
- wdata  input  DATA_W  write data
- ready  output  1  block accepts an access this cycle
- rdata  output  DATA_W  registered read data
- rvalid  output  1  one-cycle pulse: rdata updated
- err  output  1  one-cycle pulse: the accepted access was out of range

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = INIT, init pointer = 0.
  - ready = 0, rdata = 0, rvalid = 0, err = 0.
  - Memory contents are undefined until the sweep completes.
- States: INIT, IDLE. ready is registered and equals (state == IDLE).
- INIT:
  - Each rising edge writes the INIT_MODE pattern word for init pointer p into mem[p], then increments p.
  - The edge that writes p = DEPTH-1 moves the state to IDLE.
  - ready therefore first reads 1 after DEPTH edges following rst_n release.
  - req is ignored in INIT: no memory access, no rvalid, no err.
- Acceptance: an access is accepted on an edge where req && ready.
- Accepted write with addr < DEPTH: mem[addr] <= wdata at that edge. rvalid stays 0 and rdata is unchanged.
- Accepted read with addr < DEPTH: rdata <= mem[addr] at that edge, and rvalid = 1 for exactly the following cycle. Read latency is 1 cycle.
- rdata holds its value until the next accepted read or reset. It is not cleared by clr.
- Back-to-back accesses are legal every cycle; throughput is one access per clock.
  - Read of an address written on the previous edge returns the new data.
- Out of range (addr >= DEPTH, possible only when DEPTH < 2**ADDR_W):
  - Accepted write: memory is unchanged.
  - Accepted read: rdata <= 0, rvalid = 1.
  - Both cases: err = 1 for one cycle.
- clr in IDLE:
  - An access presented in the same cycle is still accepted and completed normally.
  - The state becomes INIT at that edge with p = 0. ready is 0 from the next cycle and rises again DEPTH edges later.
- clr in INIT: p restarts at 0 on that edge; the sweep takes a full DEPTH edges from there.
- rst_n asserted mid-sweep or mid-access aborts immediately to the reset values. A pending rvalid or err is lost.
- Address arithmetic: p is ADDR_W bits, and the terminal compare is against DEPTH-1, so p never wraps in INIT. INIT_MODE 2 truncates i to DATA_W bits when DATA_W < ADDR_W.

Test Plan:
- Power-up with DATA_W=8, ADDR_W=2, DEPTH=4, INIT_MODE=1 -> ready 0 for 4 edges after rst_n release, then 1. Reads of addr 0..3 return 0x00, 0xFF, 0x00, 0xFF, each with rvalid one cycle after acceptance.
- Write 0xA5 to addr 2, read addr 2 on the very next cycle -> rdata 0xA5 with rvalid 1 cycle later. A read of addr 3 in the following cycle -> 0xFF, giving back-to-back rvalid pulses.
- DEPTH=3, ADDR_W=2: write 0x3C to addr 3, then read addr 3 -> err pulses after both accesses, rdata 0x00 with rvalid. A subsequent read of addr 1 returns the init value with err 0.
- After writing 0x77 to addr 1, assert clr together with a read of addr 1 -> rdata 0x77 (the read completes), ready low for 4 cycles. A re-read of addr 1 after ready returns -> 0xFF (reinitialised).
- Assert clr at p = 2 during INIT -> sweep restarts; ready rises 4 edges after that clr edge, not 2.
- Drop rst_n mid-sweep and one cycle after a read acceptance -> ready, rvalid, err and rdata all 0 immediately (asynchronously). A full 4-edge sweep follows release.
- INIT_MODE=2, DATA_W=8, ADDR_W=3, DEPTH=8 -> reads of addr 5 and 7 return 0x05 and 0x07.

Source files
------------

// File: rtl/sram_sp_init.sv
`default_nettype none
// ============================================================================
//  Module      : sram_sp_init
//  Description : Parametrised single-port synchronous SRAM with a hardware
//                init sweep after reset or on request, a registered read,
//                out-of-range error pulses and a req/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_sp_init #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 2,
   parameter int DEPTH     = 4,
   parameter int INIT_MODE = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              ready,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid,
   output logic              err
);

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_IDLE = 1'b1
   } state_t;

   // One extra bit so DEPTH == 2**ADDR_W is representable in the range compare.
   localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_P  = ADDR_W'(DEPTH - 1);

   // Content pattern written into word p by the init sweep.
   function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] p);
      logic [DATA_W+ADDR_W-1:0] ext;
      ext = {{DATA_W{1'b0}}, p};
      case (INIT_MODE)
         1:       return {DATA_W{p[0]}};
         2:       return ext[DATA_W-1:0];
         default: return '0;
      endcase
   endfunction

   logic [DATA_W-1:0] mem [DEPTH];

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              ready_q, ready_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              rvalid_q, rvalid_d;
   logic              err_q, err_d;

   logic              accept;
   logic              in_range;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   // Next-state, access decode and memory write port selection.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      rdata_d   = rdata_q;
      rvalid_d  = 1'b0;
      err_d     = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = ptr_q;
      mem_wdata = init_word(ptr_q);
      accept    = req && ready_q;
      in_range  = {1'b0, addr} < DEPTH_X;

      if (state_q == ST_INIT) begin
         // Sweep owns the write port; requests are ignored here.
         mem_we = 1'b1;
         if (ptr_q == LAST_P) begin
            state_d = ST_IDLE;
            ptr_d   = '0;
         end else begin
            ptr_d = ptr_q + 1'b1;
         end
      end else if (accept) begin
         err_d = !in_range;
         if (we) begin
            if (in_range) begin
               mem_we    = 1'b1;
               mem_waddr = addr;
               mem_wdata = wdata;
            end
         end else begin
            rvalid_d = 1'b1;
            rdata_d  = in_range ? mem[addr] : '0;
         end
      end

      // A clear restarts the sweep; an access accepted this edge still completes.
      if (clr) begin
         state_d = ST_INIT;
         ptr_d   = '0;
      end

      ready_d = (state_d == ST_IDLE);
   end

   // Control and output registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_INIT;
         ptr_q    <= '0;
         ready_q  <= 1'b0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         ready_q  <= ready_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
      end
   end

   // Storage array; contents are undefined until the first sweep completes.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   assign ready  = ready_q;
   assign rdata  = rdata_q;
   assign rvalid = rvalid_q;
   assign err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_sp_init.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_sp_init
//  Description : Self-checking bench for sram_sp_init using three parameter
//                sets (default, DEPTH=3, INIT_MODE=2 with 8 words).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_sp_init;

   logic clk;
   logic rst_n;

   // Instance A: DATA_W=8, ADDR_W=2, DEPTH=4, INIT_MODE=1
   logic       a_clr, a_req, a_we;
   logic [1:0] a_addr;
   logic [7:0] a_wdata, a_rdata;
   logic       a_ready, a_rvalid, a_err;

   // Instance B: DEPTH=3
   logic       b_clr, b_req, b_we;
   logic [1:0] b_addr;
   logic [7:0] b_wdata, b_rdata;
   logic       b_ready, b_rvalid, b_err;

   // Instance C: ADDR_W=3, DEPTH=8, INIT_MODE=2
   logic       c_clr, c_req, c_we;
   logic [2:0] c_addr;
   logic [7:0] c_wdata, c_rdata;
   logic       c_ready, c_rvalid, c_err;

   int errors = 0;
   int checks = 0;

   sram_sp_init #(.DATA_W(8), .ADDR_W(2), .DEPTH(4), .INIT_MODE(1)) u_a (
      .clk(clk), .rst_n(rst_n), .clr(a_clr), .req(a_req), .we(a_we),
      .addr(a_addr), .wdata(a_wdata), .ready(a_ready), .rdata(a_rdata),
      .rvalid(a_rvalid), .err(a_err));

   sram_sp_init #(.DATA_W(8), .ADDR_W(2), .DEPTH(3), .INIT_MODE(1)) u_b (
      .clk(clk), .rst_n(rst_n), .clr(b_clr), .req(b_req), .we(b_we),
      .addr(b_addr), .wdata(b_wdata), .ready(b_ready), .rdata(b_rdata),
      .rvalid(b_rvalid), .err(b_err));

   sram_sp_init #(.DATA_W(8), .ADDR_W(3), .DEPTH(8), .INIT_MODE(2)) u_c (
      .clk(clk), .rst_n(rst_n), .clr(c_clr), .req(c_req), .we(c_we),
      .addr(c_addr), .wdata(c_wdata), .ready(c_ready), .rdata(c_rdata),
      .rvalid(c_rvalid), .err(c_err));

   always #5 clk = ~clk;

   typedef struct {
      logic       req;
      logic       we;
      logic [1:0] addr;
      logic [7:0] wdata;
      logic       exp_ready;
      logic       exp_rvalid;
      logic       exp_err;
      logic [7:0] exp_rdata;
   } vec_t;

   vec_t vecs [11];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      // Memory of instance A after sweep: 00 FF 00 FF
      vecs[0]  = '{1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
      vecs[1]  = '{1'b1, 1'b0, 2'd1, 8'h00, 1'b1, 1'b1, 1'b0, 8'hFF};
      vecs[2]  = '{1'b1, 1'b0, 2'd2, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
      vecs[3]  = '{1'b1, 1'b0, 2'd3, 8'h00, 1'b1, 1'b1, 1'b0, 8'hFF};
      vecs[4]  = '{1'b1, 1'b1, 2'd2, 8'hA5, 1'b1, 1'b0, 1'b0, 8'hFF};
      vecs[5]  = '{1'b1, 1'b0, 2'd2, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA5};
      vecs[6]  = '{1'b1, 1'b0, 2'd3, 8'h00, 1'b1, 1'b1, 1'b0, 8'hFF};
      vecs[7]  = '{1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hFF};
      vecs[8]  = '{1'b1, 1'b1, 2'd1, 8'h77, 1'b1, 1'b0, 1'b0, 8'hFF};
      vecs[9]  = '{1'b0, 1'b1, 2'd0, 8'h11, 1'b1, 1'b0, 1'b0, 8'hFF};
      vecs[10] = '{1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};

      clk = 1'b0;
      rst_n = 1'b0;
      a_clr = 0; a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
      b_clr = 0; b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
      c_clr = 0; c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;

      // Reset values
      tick();
      tick();
      chk("rst_ready",  a_ready,  0);
      chk("rst_rvalid", a_rvalid, 0);
      chk("rst_err",    a_err,    0);
      chk("rst_rdata",  a_rdata,  0);
      chk("rst_b_ready", b_ready, 0);

      // Power-up sweep: A ready after 4 edges, B after 3, C after 8
      rst_n = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         chk($sformatf("pwr_a_ready_e%0d", i), a_ready, (i >= 4) ? 1 : 0);
         chk($sformatf("pwr_b_ready_e%0d", i), b_ready, (i >= 3) ? 1 : 0);
         chk($sformatf("pwr_c_ready_e%0d", i), c_ready, (i >= 8) ? 1 : 0);
      end

      // Table-driven accesses on instance A
      for (int i = 0; i < 11; i++) begin
         a_req = vecs[i].req; a_we = vecs[i].we;
         a_addr = vecs[i].addr; a_wdata = vecs[i].wdata;
         tick();
         chk($sformatf("vec%0d_ready",  i), a_ready,  vecs[i].exp_ready);
         chk($sformatf("vec%0d_rvalid", i), a_rvalid, vecs[i].exp_rvalid);
         chk($sformatf("vec%0d_err",    i), a_err,    vecs[i].exp_err);
         chk($sformatf("vec%0d_rdata",  i), a_rdata,  vecs[i].exp_rdata);
      end
      a_req = 0; a_we = 0;

      // Instance B: out-of-range write then read, then in-range read
      b_req = 1; b_we = 1; b_addr = 2'd3; b_wdata = 8'h3C;
      tick();
      chk("oor_wr_err",    b_err,    1);
      chk("oor_wr_rvalid", b_rvalid, 0);
      b_we = 0; b_addr = 2'd3;
      tick();
      chk("oor_rd_err",    b_err,    1);
      chk("oor_rd_rvalid", b_rvalid, 1);
      chk("oor_rd_rdata",  b_rdata,  8'h00);
      b_addr = 2'd1;
      tick();
      chk("b_rd1_err",    b_err,    0);
      chk("b_rd1_rvalid", b_rvalid, 1);
      chk("b_rd1_rdata",  b_rdata,  8'hFF);
      b_addr = 2'd2;
      tick();
      chk("b_rd2_rdata",  b_rdata,  8'h00);
      b_req = 0;
      tick();
      chk("b_idle_err",    b_err,    0);
      chk("b_idle_rvalid", b_rvalid, 0);

      // Instance C: INIT_MODE 2 content
      c_req = 1; c_we = 0; c_addr = 3'd5;
      tick();
      chk("c_rd5_rdata",  c_rdata,  8'h05);
      chk("c_rd5_rvalid", c_rvalid, 1);
      c_addr = 3'd7;
      tick();
      chk("c_rd7_rdata",  c_rdata,  8'h07);
      c_req = 0;

      // clr together with a read of addr 1 (holds 0x77)
      a_req = 1; a_we = 0; a_addr = 2'd1; a_clr = 1;
      tick();
      chk("clr_rd_rvalid", a_rvalid, 1);
      chk("clr_rd_rdata",  a_rdata,  8'h77);
      chk("clr_rd_ready",  a_ready,  0);
      a_clr = 0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk($sformatf("clr_sweep_ready_e%0d", k), a_ready, (k == 4) ? 1 : 0);
         chk($sformatf("clr_sweep_rvalid_e%0d", k), a_rvalid, 0);
      end
      tick();
      chk("reinit_rd_rvalid", a_rvalid, 1);
      chk("reinit_rd_rdata",  a_rdata,  8'hFF);
      a_req = 0;

      // clr during INIT at p = 2 restarts the sweep
      a_clr = 1;
      tick();
      a_clr = 0;
      tick();
      tick();
      chk("p2_ready", a_ready, 0);
      a_clr = 1;
      tick();
      a_clr = 0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk($sformatf("restart_ready_e%0d", k), a_ready, (k == 4) ? 1 : 0);
      end

      // Asynchronous reset one cycle after a read acceptance and an OOR write
      a_req = 1; a_we = 0; a_addr = 2'd1;
      b_req = 1; b_we = 1; b_addr = 2'd3; b_wdata = 8'h55;
      tick();
      chk("pre_rst_rvalid", a_rvalid, 1);
      chk("pre_rst_rdata",  a_rdata,  8'hFF);
      chk("pre_rst_b_err",  b_err,    1);
      a_req = 0; b_req = 0; b_we = 0;
      rst_n = 1'b0;
      #1;
      chk("async_rst_ready",  a_ready,  0);
      chk("async_rst_rvalid", a_rvalid, 0);
      chk("async_rst_rdata",  a_rdata,  0);
      chk("async_rst_err",    a_err,    0);
      chk("async_rst_b_err",  b_err,    0);

      // Reset mid-sweep, then a full 4-edge sweep after release
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk("midsweep_rst_ready", a_ready, 0);
      tick();
      rst_n = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk($sformatf("post_rst_ready_e%0d", k), a_ready, (k == 4) ? 1 : 0);
      end
      a_req = 1; a_we = 0; a_addr = 2'd3;
      tick();
      chk("post_rst_rd3_rdata",  a_rdata,  8'hFF);
      chk("post_rst_rd3_rvalid", a_rvalid, 1);
      a_req = 0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
